// File: rtl/eq_pkg.sv
// Shared constants, FSM encoding and output saturation for the equalizer band scheduler.
// Combinational helper only; no latency, no flow control.
package eq_pkg;
   localparam int SAMPLE_W = 24;
   localparam int GAIN_W   = 8;
   localparam int BAND_W   = 4;
   localparam int N_BANDS  = 10;
   localparam int GAIN_FRAC = 6;
   localparam int GAIN_RST  = 64;
   localparam int PROD_W    = SAMPLE_W + GAIN_W + 1;
   localparam int ACC_W     = PROD_W + 4;

   localparam logic [7:0] ADDR_GAIN_BASE = 8'h01;
   localparam logic [7:0] ADDR_CTRL      = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACC,
      ST_DONE,
      ST_HOLD
   } state_t;

   // Arithmetic shift floors toward minus infinity; clamp if any bit above the sign is lost.
   function automatic logic [SAMPLE_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] shifted;
      shifted = acc >>> GAIN_FRAC;
      if ((&shifted[ACC_W-1:SAMPLE_W-1]) || (~|shifted[ACC_W-1:SAMPLE_W-1]))
         return shifted[SAMPLE_W-1:0];
      else if (shifted[ACC_W-1])
         return {1'b1, {(SAMPLE_W-1){1'b0}}};
      else
         return {1'b0, {(SAMPLE_W-1){1'b1}}};
   endfunction
endpackage

// File: rtl/eq_gain_bank.sv
// Per-band live gain registers with a shadow copy taken on the snapshot strobe.
// Writes land on the next edge; no backpressure, writes accepted at any time.
module eq_gain_bank
   import eq_pkg::*;
(
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_we,
   input  logic [7:0]                     i_addr,
   input  logic [GAIN_W-1:0]              i_wdata,
   input  logic                           i_snap,
   output logic [N_BANDS-1:0][GAIN_W-1:0] o_shadow
);
   logic [N_BANDS-1:0][GAIN_W-1:0] r_live;
   logic [N_BANDS-1:0][GAIN_W-1:0] r_shadow;
   logic [N_BANDS-1:0]             w_hit;

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < N_BANDS; i++)
         w_hit[i] = i_we && (i_addr == ADDR_GAIN_BASE + 8'(i));
   end

   // A snapshot coinciding with a write captures the pre-write value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < N_BANDS; i++) begin
            r_live[i]   <= GAIN_W'(GAIN_RST);
            r_shadow[i] <= GAIN_W'(GAIN_RST);
         end
      end else begin
         for (int i = 0; i < N_BANDS; i++)
            if (w_hit[i])
               r_live[i] <= i_wdata;
         if (i_snap)
            r_shadow <= r_live;
      end
   end

   assign o_shadow = r_shadow;
endmodule

// File: rtl/eq_band_scheduler.sv
// Runs each sample through all bands on a shared engine, gain-weights and sums; out_valid 2*N_BANDS+2 edges after accept.
// in_ready low from accept until the output is taken; EQ_SCHED_BYPASS_EN adds ctrl reg 0x00 bit0 bypass (1-cycle path).
module eq_band_scheduler
   import eq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [7:0]          cfg_addr,
   input  logic [7:0]          cfg_wdata,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic                eng_req,
   output logic [BAND_W-1:0]   eng_band,
   output logic [SAMPLE_W-1:0] eng_sample,
   input  logic                eng_ack,
   input  logic [SAMPLE_W-1:0] eng_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SAMPLE_W-1:0] out_data,
   output logic                busy
);
   state_t                         r_state;
   logic                           r_in_ready;
   logic                           r_eng_req;
   logic [BAND_W-1:0]              r_band;
   logic [SAMPLE_W-1:0]            r_sample;
   logic signed [PROD_W-1:0]       r_prod;
   logic signed [ACC_W-1:0]        r_acc;
   logic                           r_out_valid;
   logic [SAMPLE_W-1:0]            r_out_data;
   logic                           r_busy;

   logic [N_BANDS-1:0][GAIN_W-1:0] w_shadow;
   logic [GAIN_W-1:0]              w_gain;
   logic signed [PROD_W-1:0]       w_prod;
   logic                           w_accept;
   logic                           w_last;
   logic                           w_bypass;

`ifdef EQ_SCHED_BYPASS_EN
   logic r_bypass;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_bypass <= 1'b0;
      else if (cfg_we && (cfg_addr == ADDR_CTRL))
         r_bypass <= cfg_wdata[0];
   end

   assign w_bypass = r_bypass;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_accept = (r_state == ST_IDLE) && r_in_ready && in_valid;
   assign w_last   = (r_band == BAND_W'(N_BANDS - 1));
   assign w_gain   = w_shadow[r_band];
   // Gain is an unsigned code, so it is zero-extended before the signed multiply.
   assign w_prod   = PROD_W'($signed(eng_data)) * PROD_W'($signed({1'b0, w_gain}));

   eq_gain_bank u_gain_bank (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_we     (cfg_we),
      .i_addr   (cfg_addr),
      .i_wdata  (cfg_wdata),
      .i_snap   (w_accept),
      .o_shadow (w_shadow)
   );

   // The product is registered on ack and summed in ACC, so the last band also passes through ACC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_eng_req   <= 1'b0;
         r_band      <= '0;
         r_sample    <= '0;
         r_prod      <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_acc      <= '0;
                  r_band     <= '0;
                  r_sample   <= in_data;
                  if (w_bypass) begin
                     r_out_data  <= in_data;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_HOLD;
                  end else begin
                     r_eng_req <= 1'b1;
                     r_state   <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (eng_ack) begin
                  r_prod    <= w_prod;
                  r_eng_req <= 1'b0;
                  r_state   <= ST_ACC;
               end
            end
            ST_ACC: begin
               r_acc <= r_acc + ACC_W'(r_prod);
               if (w_last) begin
                  r_state <= ST_DONE;
               end else begin
                  r_band    <= r_band + 1'b1;
                  r_eng_req <= 1'b1;
                  r_state   <= ST_REQ;
               end
            end
            ST_DONE: begin
               r_out_data  <= sat_out(r_acc);
               r_out_valid <= 1'b1;
               r_state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign eng_req    = r_eng_req;
   assign eng_band   = r_band;
   assign eng_sample = r_sample;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign busy       = r_busy;
endmodule

// File: doc/eq_band_scheduler.md
Name: eq_band_scheduler

Overview:
Sequences one shared band-filter engine across all equalizer bands for each incoming 24-bit audio sample. It also owns the per-band gain register bank, which the I2C slave writes at addresses 0x01..0x0A. For each accepted sample it requests every band from the engine in order, scales each result by a snapshot of that band's gain, and accumulates. The saturated sum is presented on a valid/ready output toward the audio sink.

Parameters:
N_BANDS, 10, number of bands; gain register addresses 0x01..N_BANDS
GAIN_FRAC, 6, fractional bits of the gain code; linear gain = code / 2^GAIN_FRAC
GAIN_RST, 64, reset gain code (unity, 0 dB)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
cfg_we  in  1  gain register write strobe
cfg_addr  in  8  register address
cfg_wdata  in  8  gain code, unsigned 0..255
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  24  signed input sample
eng_req  out  1  engine request
eng_band  out  4  band index 0..N_BANDS-1
eng_sample  out  24  sample under processing
eng_ack  in  1  engine result valid; honoured only while eng_req=1
eng_data  in  24  signed band output
out_valid  out  1  output sample valid
out_ready  in  1  sink accepts output
out_data  out  24  signed equalized sample
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): in_ready=0 while rst is high, then 1 in IDLE. eng_req=0, eng_band=0, eng_sample=0, out_valid=0, out_data=0, busy=0. Accumulator is cleared. All gain registers reset to GAIN_RST.
- Reset mid-operation: any in-flight sample is discarded and eng_req drops at once. A late eng_ack is ignored.
- Gain writes: a write with cfg_we=1 and cfg_addr in 1..N_BANDS updates gain[addr-1] on the next edge. Other addresses are ignored. Writes are accepted in any state.
- Gain snapshot: gains are copied into a shadow bank on input acceptance. A sample always uses one consistent gain set; writes during processing apply from the next sample.
- FSM states: IDLE, REQ, ACC, DONE, HOLD.
  - IDLE: in_ready=1. When in_valid&in_ready at edge T: latch sample, take snapshot, clear acc, band=0, go to REQ.
  - REQ: eng_req=1 with eng_band and eng_sample stable. eng_ack may arrive in the same cycle or any later cycle. On ack, acc += eng_data * shadow_gain[band].
    - If band==N_BANDS-1, go to DONE; otherwise band++ and stay in REQ.
    - eng_req deasserts for one cycle between bands (ACC bubble): REQ -> ACC -> REQ.
  - DONE: out_data = sat24(acc >>> GAIN_FRAC), using an arithmetic shift with truncation toward minus infinity. Go to HOLD.
  - HOLD: out_valid=1 with out_data stable. When out_ready=1, go to IDLE; in_ready rises in the next cycle.
- Latency with a same-cycle-ack engine: band b requested at T+1+2b; out_valid rises at T+2·N_BANDS+2 (22 cycles for 10 bands).
- Arithmetic:
  - Product is 24x9 signed, with the gain zero-extended.
  - Accumulator is 24+9+4 = 37 bits signed and cannot overflow.
  - Saturation clamps to 0x7FFFFF / 0x800000.
- There is no input/output overlap: in_ready=0 from acceptance until HOLD is released.

Optional Feature:
EQ_SCHED_BYPASS_EN
- Defined: adds control register 0x00, bit0 = bypass, reset value 0.
  - With bypass=1, an accepted sample goes IDLE -> HOLD directly, with out_data = in_data.
  - No engine request is made; latency is 1 cycle.
- Undefined: address 0x00 is ignored and there is no bypass path.

Decomposition:
- Shared package eq_pkg holds:
  - constants N_BANDS, GAIN_FRAC, GAIN_RST, ADDR_GAIN_BASE=0x01, ADDR_CTRL=0x00
  - the FSM state encoding
  - the 24-bit sample width constant
- One natural sub-module, eq_gain_bank: N_BANDS x 8-bit live registers plus a shadow snapshot, with write decode and a snapshot strobe.

Test Plan:
- Engine model returns eng_data=eng_sample. Gains: band0=64, all others written to 0. in_data=0x123456 -> out_data=0x123456; out_valid at T+22.
- Reset defaults (all gains 64), same engine model. in_data=0x000100 -> out_data=0x000A00 (sum of 10 unity bands).
- All gains 255, in_data=0x400000 -> out_data=0x7FFFFF. in_data=0xC00000 -> out_data=0x800000.
- Gain written to band3=0 during REQ of band 5, with engine model returning eng_sample only for band3 and 0 otherwise. Current sample uses old gain 64 (out=in); next sample -> out_data=0.
- Engine acks with 3-cycle delay and out_ready held low for 5 cycles. eng_req stays high until ack; out_data stays stable; in_ready=0 until release.
- rst asserted during band 4 REQ. eng_req=0, out_valid=0, busy=0 immediately; gains read back as 64; next sample is processed normally.
